spi_slave_datapath: RTL and testbench

//  Datapath half of the SPI memory slave; sits directly downstream of the SPI control FSM.

---
 rtl/spi_slave_datapath.sv | 84 ++++++++
 tb/tb_spi_slave_datapath.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_datapath.sv
// SPI memory slave datapath: MOSI shift register, address latch, data memory
// and MISO launch, all sequenced by strobes from the SPI control FSM.
module spi_slave_datapath #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = WIDTH - 1,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic sclk_pin,
    input  logic reset_counter,
    input  logic cs_pin,
    input  logic mosi_pin,
    input  logic shift_wren,
    input  logic addr_wren,
    input  logic dm_wren,
    input  logic miso_en,
    output logic rw,
    output logic byte_done,
    output logic miso_pin,
    output logic miso_oe
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]      shift_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  miso_q;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [WIDTH-1:0]      mem_rd;

    // Combinational memory read so a parallel load costs no extra cycle.
    assign mem_rd = mem[addr_q];

    // Shift register, address latch and byte counter on the rising edge.
    always_ff @(posedge sclk_pin or posedge reset_counter) begin
        if (reset_counter) begin
            shift_q   <= '0;
            addr_q    <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
        end else if (cs_pin) begin
            // Deselect discards any partial byte; data registers hold.
            bit_cnt   <= '0;
            byte_done <= 1'b0;
        end else begin
            if (shift_wren) begin
                shift_q   <= mem_rd;
                byte_done <= 1'b0;
            end else begin
                shift_q   <= {shift_q[WIDTH-2:0], mosi_pin};
                bit_cnt   <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
                byte_done <= (bit_cnt == CNT_LAST);
            end
            if (addr_wren) begin
                addr_q <= shift_q[WIDTH-1:1];
            end
        end
    end

    // Memory write uses pre-edge addr_q/shift_q; an edge coinciding with reset writes nothing.
    always_ff @(posedge sclk_pin or posedge reset_counter) begin
        if (!reset_counter && !cs_pin && dm_wren) begin
            mem[addr_q] <= shift_q;
        end
    end

    // Launch the MSB on the falling edge so the master samples it on the next rising edge.
    always_ff @(negedge sclk_pin or posedge reset_counter) begin
        if (reset_counter) begin
            miso_q <= 1'b0;
        end else begin
            miso_q <= shift_q[WIDTH-1];
        end
    end

    // Pad enable is also forced low while reset is held.
    always_comb begin
        miso_oe  = miso_en & ~cs_pin & ~reset_counter;
        miso_pin = miso_oe ? miso_q : 1'b0;
        rw       = shift_q[0];
    end

endmodule

// File: tb/tb_spi_slave_datapath.sv
// Self-checking bench for spi_slave_datapath: a table of byte transfers plus
// hand-written sequences for same-edge strobe interactions, deselect and reset.
module tb_spi_slave_datapath;

    logic sclk_pin      = 1'b0;
    logic reset_counter = 1'b0;
    logic cs_pin        = 1'b1;
    logic mosi_pin      = 1'b0;
    logic shift_wren    = 1'b0;
    logic addr_wren     = 1'b0;
    logic dm_wren       = 1'b0;
    logic miso_en       = 1'b0;
    logic rw, byte_done, miso_pin, miso_oe;

    int n_pass  = 0;
    int n_total = 0;

    spi_slave_datapath dut (
        .sclk_pin      (sclk_pin),
        .reset_counter (reset_counter),
        .cs_pin        (cs_pin),
        .mosi_pin      (mosi_pin),
        .shift_wren    (shift_wren),
        .addr_wren     (addr_wren),
        .dm_wren       (dm_wren),
        .miso_en       (miso_en),
        .rw            (rw),
        .byte_done     (byte_done),
        .miso_pin      (miso_pin),
        .miso_oe       (miso_oe)
    );

    always #5 sclk_pin = ~sclk_pin;

    typedef struct {
        logic [7:0] data;
        logic       aw;
        logic [7:0] exp_shift;
        logic       exp_rw;
        logic [6:0] exp_addr;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One rising edge: inputs set after the falling edge, strobes cleared after the rising edge.
    task automatic edge1(input logic m, input logic sw, input logic aw, input logic dw);
        @(negedge sclk_pin);
        #1;
        mosi_pin   = m;
        shift_wren = sw;
        addr_wren  = aw;
        dm_wren    = dw;
        @(posedge sclk_pin);
        #1;
        shift_wren = 1'b0;
        addr_wren  = 1'b0;
        dm_wren    = 1'b0;
    endtask

    // Shift a byte MSB first; optional addr_wren on its first edge; counts early byte_done pulses.
    task automatic shift_byte(input logic [7:0] b, input logic aw, output int early);
        early = 0;
        for (int i = 7; i >= 0; i--) begin
            edge1(b[i], 1'b0, (i == 7) && aw, 1'b0);
            if (i > 0 && byte_done) early++;
        end
    endtask

    task automatic go_idle();
        cs_pin = 1'b1;
        @(posedge sclk_pin);
        #1;
    endtask

    task automatic write_mem(input logic [6:0] a, input logic [7:0] d);
        int e;
        go_idle();
        cs_pin = 1'b0;
        shift_byte({a, 1'b0}, 1'b0, e);
        shift_byte(d, 1'b1, e);
        edge1(1'b0, 1'b0, 1'b0, 1'b1);
        go_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int         early;
        logic [7:0] got;

        vecs[0] = '{8'hA4, 1'b0, 8'hA4, 1'b0, 7'h00};
        vecs[1] = '{8'h3C, 1'b1, 8'h3C, 1'b0, 7'h52};
        vecs[2] = '{8'h23, 1'b1, 8'h23, 1'b1, 7'h1E};
        vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 7'h11};
        vecs[4] = '{8'h80, 1'b1, 8'h80, 1'b0, 7'h7F};

        // Reset state
        #2;
        reset_counter = 1'b1;
        repeat (2) @(posedge sclk_pin);
        #1;
        chk("rst_rw",        rw,          0);
        chk("rst_byte_done", byte_done,   0);
        chk("rst_miso_pin",  miso_pin,    0);
        chk("rst_miso_oe",   miso_oe,     0);
        chk("rst_shift_q",   dut.shift_q, 0);
        chk("rst_addr_q",    dut.addr_q,  0);
        chk("rst_bit_cnt",   dut.bit_cnt, 0);
        reset_counter = 1'b0;

        // Table: back-to-back bytes, each latching the previous byte as address
        cs_pin = 1'b0;
        for (int v = 0; v < 5; v++) begin
            shift_byte(vecs[v].data, vecs[v].aw, early);
            chk($sformatf("tbl%0d_early_done", v), early, 0);
            chk($sformatf("tbl%0d_byte_done", v), byte_done, 1);
            chk($sformatf("tbl%0d_shift", v), dut.shift_q, vecs[v].exp_shift);
            chk($sformatf("tbl%0d_rw", v), rw, vecs[v].exp_rw);
            chk($sformatf("tbl%0d_addr", v), dut.addr_q, vecs[v].exp_addr);
        end
        go_idle();

        // Write transaction: mem[0x52] = 0x3C
        cs_pin = 1'b0;
        shift_byte(8'hA4, 1'b0, early);
        chk("wr_done1", byte_done, 1);
        chk("wr_rw", rw, 0);
        shift_byte(8'h3C, 1'b1, early);
        chk("wr_done2", byte_done, 1);
        chk("wr_addr", dut.addr_q, 7'h52);
        edge1(1'b0, 1'b0, 1'b0, 1'b1);
        chk("wr_mem52", dut.mem[7'h52], 8'h3C);
        go_idle();

        write_mem(7'h11, 8'h96);
        write_mem(7'h7F, 8'h5A);
        write_mem(7'h40, 8'h11);
        write_mem(7'h00, 8'h77);
        chk("pre_mem11", dut.mem[7'h11], 8'h96);

        // Read transaction: mem[0x11]=0x96 serialised on MISO
        cs_pin = 1'b0;
        shift_byte(8'h23, 1'b0, early);
        chk("rd_rw", rw, 1);
        edge1(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rd_addr", dut.addr_q, 7'h11);
        edge1(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rd_load", dut.shift_q, 8'h96);
        miso_en = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            @(negedge sclk_pin);
            #2;
            got[i] = miso_pin;
        end
        chk("rd_miso_bits", got, 8'h96);
        chk("rd_miso_oe", miso_oe, 1);
        @(posedge sclk_pin);
        #1;
        go_idle();

        // Same-edge addr_wren + dm_wren uses the old address
        cs_pin = 1'b0;
        shift_byte(8'h0A, 1'b0, early);
        shift_byte(8'hFF, 1'b1, early);
        chk("aw_dw_pre_addr", dut.addr_q, 7'h05);
        edge1(1'b1, 1'b0, 1'b1, 1'b1);
        chk("aw_dw_mem05", dut.mem[7'h05], 8'hFF);
        chk("aw_dw_addr", dut.addr_q, 7'h7F);
        chk("aw_dw_mem7f", dut.mem[7'h7F], 8'h5A);
        go_idle();

        // Same-edge shift_wren + dm_wren swaps register and memory
        cs_pin = 1'b0;
        shift_byte(8'h80, 1'b0, early);
        shift_byte(8'h22, 1'b1, early);
        edge1(1'b0, 1'b1, 1'b0, 1'b1);
        chk("sw_dw_mem40", dut.mem[7'h40], 8'h22);
        chk("sw_dw_shift", dut.shift_q, 8'h11);
        go_idle();

        // Deselect mid-byte discards the partial count
        miso_en = 1'b1;
        cs_pin  = 1'b0;
        for (int i = 0; i < 5; i++) edge1(1'b1, 1'b0, 1'b0, 1'b0);
        chk("cs_partial_cnt", dut.bit_cnt, 5);
        chk("cs_partial_done", byte_done, 0);
        go_idle();
        chk("cs_idle_cnt", dut.bit_cnt, 0);
        chk("cs_idle_oe", miso_oe, 0);
        chk("cs_idle_miso", miso_pin, 0);
        edge1(1'b1, 1'b1, 1'b1, 1'b1);
        chk("cs_idle_shift_hold", dut.shift_q, 8'h3F);
        chk("cs_idle_addr_hold", dut.addr_q, 7'h40);
        chk("cs_idle_mem_hold", dut.mem[7'h40], 8'h22);
        cs_pin = 1'b0;
        shift_byte(8'hC3, 1'b0, early);
        chk("cs_new_early", early, 0);
        chk("cs_new_done", byte_done, 1);
        edge1(1'b0, 1'b0, 1'b0, 1'b0);
        chk("cs_done_one_cycle", byte_done, 0);
        go_idle();

        // Reset mid-byte, with a write pending on the edge under reset
        cs_pin = 1'b0;
        shift_byte(8'h1F, 1'b0, early);
        for (int i = 0; i < 3; i++) edge1(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge sclk_pin);
        #2;
        chk("rst_mid_cnt_before", dut.bit_cnt, 3);
        chk("rst_mid_miso_before", miso_pin, 1);
        reset_counter = 1'b1;
        #1;
        chk("rst_mid_shift", dut.shift_q, 0);
        chk("rst_mid_cnt", dut.bit_cnt, 0);
        chk("rst_mid_miso", miso_pin, 0);
        chk("rst_mid_oe", miso_oe, 0);
        dm_wren = 1'b1;
        @(posedge sclk_pin);
        #1;
        dm_wren = 1'b0;
        chk("rst_mid_mem00", dut.mem[7'h00], 8'h77);
        chk("rst_mid_mem52", dut.mem[7'h52], 8'h3C);
        chk("rst_mid_mem11", dut.mem[7'h11], 8'h96);
        cs_pin = 1'b1;
        reset_counter = 1'b0;
        @(posedge sclk_pin);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
